// File: rtl/bcd2bin_pkg.sv
// Shared types and digit constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One digit-field correction cell of the reverse double-dabble step.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Subtract 3 from fields that reached 8 after the right shift
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESH) begin
            o_digit = i_digit - ADJ_VAL;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one shift-right-and-correct step per clock,
// start/busy/done handshake, invalid digits and oversize residues flagged via err.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int Z_W   = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_t             r_state, w_state_nxt;
    logic [Z_W-1:0]     r_z, w_z_nxt, w_z_shift, w_z_step;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BIN_W-1:0]   r_bin, w_bin_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic               w_bcd_ok;
    logic               w_residue;

    assign w_z_shift = r_z >> 1;
    assign w_z_step[BIN_W-1:0] = w_z_shift[BIN_W-1:0];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (w_z_shift[BIN_W + 4*g +: 4]),
                .o_digit (w_z_step[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    // Any leftover digit content after the final step means BIN_W is too narrow
    assign w_residue = |w_z_step[Z_W-1:BIN_W];

    // Input digit validity across all fields
    always_comb begin
        w_bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_bcd_ok = w_bcd_ok & bcd_valid(bcd[4*i +: 4]);
        end
    end

    // Next-state, datapath and output-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_z_nxt     = r_z;
        w_cnt_nxt   = r_cnt;
        w_bin_nxt   = r_bin;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_bcd_ok) begin
                        w_z_nxt     = {bcd, {BIN_W{1'b0}}};
                        w_cnt_nxt   = CNT_ZERO;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_bin_nxt  = {BIN_W{1'b0}};
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            SHIFT: begin
                w_z_nxt   = w_z_step;
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (r_cnt == LAST_STEP) begin
                    w_bin_nxt   = w_residue ? {BIN_W{1'b0}} : w_z_step[BIN_W-1:0];
                    w_err_nxt   = w_residue;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_z     <= {Z_W{1'b0}};
            r_cnt   <= CNT_ZERO;
            r_bin   <= {BIN_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_z     <= w_z_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bin   <= w_bin_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bin  = r_bin;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq, including two non-default parameterisations.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        start = 1'b0;
    logic [11:0] bcd = 12'h000;
    logic [9:0]  bin;
    logic        busy, done, err;

    logic        start4 = 1'b0;
    logic [15:0] bcd4 = 16'h0000;
    logic [13:0] bin4;
    logic        busy4, done4, err4;

    logic        start9 = 1'b0;
    logic [11:0] bcd9 = 12'h000;
    logic [8:0]  bin9;
    logic        busy9, done9, err9;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bcd(bcd),
        .bin(bin), .busy(busy), .done(done), .err(err));

    bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .bcd(bcd4),
        .bin(bin4), .busy(busy4), .done(done4), .err(err4));

    bcd2bin_seq #(.DIGITS(3), .BIN_W(9)) dut9 (
        .clk(clk), .reset_n(reset_n), .start(start9), .bcd(bcd9),
        .bin(bin9), .busy(busy9), .done(done9), .err(err9));

    // Pulse start on the main DUT for one rising edge
    task automatic do_start(input logic [11:0] v);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done on the main DUT; lat is edges after the accepting edge, -1 on timeout
    task automatic wait_done(output int lat, output int bc, output logic [9:0] b,
                             output logic e, output logic ov);
        int n;
        logic got;
        n = 0; got = 1'b0; lat = -1; bc = 0; b = 10'd0; e = 1'b0; ov = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (busy && done) ov = 1'b1;
            if (done) begin
                got = 1'b1;
                lat = n - 1;
                b   = bin;
                e   = err;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; start4 = 1'b0; start9 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bin, busy, done, err} !== 13'd0) $display("FAIL reset_main got bin=%0d busy=%b done=%b err=%b want all 0", bin, busy, done, err);
        else n_pass++;
        n_checks++;
        if ({bin4, busy4, done4, err4, bin9, busy9, done9, err9} !== 29'd0) $display("FAIL reset_param got bin4=%0d bin9=%0d want 0", bin4, bin9);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc; logic [9:0] b; logic e, ov;
        logic [11:0] vin [3]  = '{12'h255, 12'h999, 12'h000};
        logic [9:0]  vexp [3] = '{10'd255, 10'd999, 10'd0};
        for (int i = 0; i < 3; i++) begin
            do_start(vin[i]);
            wait_done(lat, bc, b, e, ov);
            n_checks++;
            if (lat != 10 || bc != 10 || ov !== 1'b0) $display("FAIL timing_%h got lat=%0d busy_cycles=%0d overlap=%b want 10/10/0", vin[i], lat, bc, ov);
            else n_pass++;
            n_checks++;
            if (b !== vexp[i] || e !== 1'b0) $display("FAIL value_%h got bin=%0d err=%b want %0d/0", vin[i], b, e, vexp[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || bin !== 10'd0) $display("FAIL done_pulse got done=%b bin=%0d want 0/0", done, bin);
        else n_pass++;
    endtask

    task automatic test_sweep();
        int lat, bc; logic [9:0] b; logic e, ov;
        logic [11:0] v; logic [9:0] x;
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int o = 0; o < 10; o++) begin
                    v = {4'(h), 4'(t), 4'(o)};
                    x = 10'(h*100 + t*10 + o);
                    do_start(v);
                    wait_done(lat, bc, b, e, ov);
                    n_checks++;
                    if (b !== x || e !== 1'b0 || lat != 10) $display("FAIL sweep_%h got bin=%0d err=%b lat=%0d want %0d/0/10", v, b, e, lat, x);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_invalid();
        int lat, bc; logic [9:0] b; logic e, ov;
        do_start(12'h1A5);
        wait_done(lat, bc, b, e, ov);
        n_checks++;
        if (lat != 0 || bc != 0 || b !== 10'd0 || e !== 1'b1) $display("FAIL invalid_1A5 got lat=%0d busy_cycles=%0d bin=%0d err=%b want 0/0/0/1", lat, bc, b, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) $display("FAIL invalid_hold got done=%b err=%b busy=%b want 0/1/0", done, err, busy);
        else n_pass++;
        do_start(12'h100);
        wait_done(lat, bc, b, e, ov);
        n_checks++;
        if (lat != 10 || b !== 10'd100 || e !== 1'b0) $display("FAIL after_invalid got lat=%0d bin=%0d err=%b want 10/100/0", lat, b, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, lat, lat2, dones;
        logic [9:0] b, b2;
        do_start(12'h042);
        n = 0; lat = -1; b = 10'd0;
        while (lat < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 3) begin start = 1'b1; bcd = 12'h777; end
            if (n == 4) start = 1'b0;
            if (done) begin lat = n - 1; b = bin; end
        end
        n_checks++;
        if (lat != 10 || b !== 10'd42) $display("FAIL ignore_start got lat=%0d bin=%0d want 10/42", lat, b);
        else n_pass++;
        start = 1'b1;
        bcd   = 12'h777;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 12'h000;
        n = 0; lat2 = -1; b2 = 10'd0; dones = 0;
        while (n < 25) begin
            @(negedge clk);
            n++;
            if (done) begin
                dones++;
                if (lat2 < 0) begin lat2 = n - 1; b2 = bin; end
            end
        end
        n_checks++;
        if (lat2 != 10 || b2 !== 10'd777) $display("FAIL back_to_back got lat=%0d bin=%0d want 10/777", lat2, b2);
        else n_pass++;
        n_checks++;
        if (dones != 1) $display("FAIL no_queue got done_count=%0d want 1", dones);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat, bc; logic [9:0] b; logic e, ov;
        int dones;
        do_start(12'h123);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bin !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL abort_state got bin=%0d busy=%b done=%b err=%b want 0/0/0/0", bin, busy, done, err);
        else n_pass++;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones != 0) $display("FAIL abort_quiet got active_cycles=%0d want 0", dones);
        else n_pass++;
        do_start(12'h321);
        wait_done(lat, bc, b, e, ov);
        n_checks++;
        if (lat != 10 || b !== 10'd321 || e !== 1'b0) $display("FAIL after_abort got lat=%0d bin=%0d err=%b want 10/321/0", lat, b, e);
        else n_pass++;
    endtask

    task automatic test_params();
        int n, lat;
        logic [13:0] b4; logic e4;
        logic [8:0] b9; logic e9;
        logic [11:0] v9 [2]   = '{12'h600, 12'h511};
        logic [8:0]  x9 [2]   = '{9'd0, 9'd511};
        logic        xe9 [2]  = '{1'b1, 1'b0};
        @(negedge clk);
        bcd4 = 16'h9999; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0; lat = -1; b4 = 14'd0; e4 = 1'b0;
        while (lat < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (done4) begin lat = n - 1; b4 = bin4; e4 = err4; end
        end
        n_checks++;
        if (lat != 14 || b4 !== 14'd9999 || e4 !== 1'b0) $display("FAIL w14_9999 got lat=%0d bin=%0d err=%b want 14/9999/0", lat, b4, e4);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bcd9 = v9[i]; start9 = 1'b1;
            @(posedge clk);
            #1;
            start9 = 1'b0;
            n = 0; lat = -1; b9 = 9'd0; e9 = 1'b0;
            while (lat < 0 && n < 30) begin
                @(negedge clk);
                n++;
                if (done9) begin lat = n - 1; b9 = bin9; e9 = err9; end
            end
            n_checks++;
            if (lat != 9 || b9 !== x9[i] || e9 !== xe9[i]) $display("FAIL w9_%h got lat=%0d bin=%0d err=%b want 9/%0d/%b", v9[i], lat, b9, e9, x9[i], xe9[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_reset_abort();
        test_back_to_back();
        test_params();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
